// File: rtl/video_pkg.sv
// video_pkg: shared pixel/strobe types and constants for the video pipeline
package video_pkg;
  localparam int DEFAULT_PIX_W = 24;
  localparam int COMPOSITOR_LATENCY = 2;
  typedef logic [DEFAULT_PIX_W-1:0] pixel_t;
  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
    logic blank;
  } vid_strobe_t;
  localparam pixel_t BLACK = '0;
endpackage

// File: rtl/video_compositor_priority_overlay.sv
// priority_overlay: lowest-index-wins overlay selector, optional 50% blend (VIDEO_COMPOSITOR_BLEND_EN)
module priority_overlay
  import video_pkg::*;
#(
  parameter int NUM_OVL = 2,
  parameter int PIX_W   = 24
) (
  input  logic [PIX_W-1:0]         bg_in,
  input  logic [NUM_OVL-1:0]       mask_in,
  input  logic [NUM_OVL-1:0]       blend_in,
  input  logic [NUM_OVL*PIX_W-1:0] color_in,
  output logic [PIX_W-1:0]         pixel_out
);
  localparam int C = PIX_W / 3;
`ifdef VIDEO_COMPOSITOR_BLEND_EN
  function automatic logic [PIX_W-1:0] mix(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    for (int k = 0; k < 3; k++)
      mix[k*C +: C] = {1'b0, a[k*C+1 +: C-1]} + {1'b0, b[k*C+1 +: C-1]};
  endfunction
  // scan from lowest priority up so the lowest set index ends up winning
  always_comb begin
    pixel_out = bg_in;
    for (int i = NUM_OVL - 1; i >= 0; i--)
      if (mask_in[i]) pixel_out = blend_in[i] ? mix(bg_in, color_in[i*PIX_W +: PIX_W]) : color_in[i*PIX_W +: PIX_W];
  end
`else
  logic unused_blend;
  assign unused_blend = ^blend_in;
  // scan from lowest priority up so the lowest set index ends up winning
  always_comb begin
    pixel_out = bg_in;
    for (int i = NUM_OVL - 1; i >= 0; i--)
      if (mask_in[i]) pixel_out = color_in[i*PIX_W +: PIX_W];
  end
`endif
endmodule

// File: rtl/video_compositor.sv
// video_compositor: 2-stage background select + overlay compositor, config latched on vsync rise (blend via VIDEO_COMPOSITOR_BLEND_EN)
module video_compositor
  import video_pkg::*;
#(
  parameter int NUM_BG  = 4,
  parameter int NUM_OVL = 2,
  parameter int PIX_W   = 24
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [$clog2(NUM_BG)-1:0]   bg_sel_in,
  input  logic [NUM_OVL-1:0]          ovl_en_in,
  input  logic [NUM_OVL-1:0]          ovl_blend_in,
  input  logic [NUM_BG*PIX_W-1:0]     bg_pixel_in,
  input  logic [NUM_OVL-1:0]          ovl_mask_in,
  input  logic [NUM_OVL*PIX_W-1:0]    ovl_color_in,
  input  logic                        valid_in,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        blank_in,
  output logic [PIX_W-1:0]            pixel_out,
  output logic                        valid_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        blank_out,
  output logic                        cfg_pending_out
);
  localparam int BW = $clog2(NUM_BG);
  logic vs_prev, vs_edge;
  logic [BW-1:0] act_bg;
  logic [NUM_OVL-1:0] act_en, s1_mask, s1_blend;
  logic [PIX_W-1:0] s1_bg, ovl_pix;
  logic [NUM_OVL*PIX_W-1:0] s1_col;
  vid_strobe_t s1_strb;
  logic [PIX_W-1:0] bg_arr [2**BW];
  assign vs_edge = vsync_in & ~vs_prev;
  genvar g;
  for (g = 0; g < 2**BW; g++) begin : g_bg
    if (g < NUM_BG) begin : g_src
      assign bg_arr[g] = bg_pixel_in[g*PIX_W +: PIX_W];
    end else begin : g_oob
      assign bg_arr[g] = '0;
    end
  end
`ifdef VIDEO_COMPOSITOR_BLEND_EN
  logic [NUM_OVL-1:0] act_blend;
  // blend modes shadow like the rest of the config; stage 1 carries them with the pixel
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      act_blend <= '0;
      s1_blend  <= '0;
    end else begin
      if (vs_edge) act_blend <= ovl_blend_in;
      s1_blend <= act_blend;
    end
  assign cfg_pending_out = (bg_sel_in != act_bg) | (ovl_en_in != act_en) | (ovl_blend_in != act_blend);
`else
  logic unused_blend;
  assign unused_blend = ^ovl_blend_in;
  assign s1_blend = '0;
  assign cfg_pending_out = (bg_sel_in != act_bg) | (ovl_en_in != act_en);
`endif
  // active config loads only on a vsync rising edge; vs_prev resets high to ignore a held vsync
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      vs_prev <= 1'b1;
      act_bg  <= '0;
      act_en  <= '0;
    end else begin
      vs_prev <= vsync_in;
      if (vs_edge) begin
        act_bg <= bg_sel_in;
        act_en <= ovl_en_in;
      end
    end
  // stage 1: background select, enable-gated masks, colours and strobes
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      s1_bg   <= '0;
      s1_mask <= '0;
      s1_col  <= '0;
      s1_strb <= vid_strobe_t'(4'b0001);
    end else begin
      s1_bg   <= bg_arr[act_bg];
      s1_mask <= ovl_mask_in & act_en;
      s1_col  <= ovl_color_in;
      s1_strb <= vid_strobe_t'({valid_in, hsync_in, vsync_in, blank_in});
    end
  priority_overlay #(.NUM_OVL(NUM_OVL), .PIX_W(PIX_W)) u_ovl (
    .bg_in(s1_bg),
    .mask_in(s1_mask),
    .blend_in(s1_blend),
    .color_in(s1_col),
    .pixel_out(ovl_pix)
  );
  // stage 2: composite result, forced black during blanking
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      pixel_out <= '0;
      valid_out <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b1;
    end else begin
      pixel_out <= s1_strb.blank ? '0 : ovl_pix;
      valid_out <= s1_strb.valid;
      hsync_out <= s1_strb.hsync;
      vsync_out <= s1_strb.vsync;
      blank_out <= s1_strb.blank;
    end
endmodule

// File: tb/tb_video_compositor.sv
// tb_video_compositor: directed self-checking bench for video_compositor
module tb_video_compositor;
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic [1:0] bg_sel_in = '0, ovl_en_in = '0, ovl_blend_in = '0, ovl_mask_in = '0;
  logic [95:0] bg_pixel_in;
  logic [47:0] ovl_color_in = '0;
  logic valid_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b0;
  logic [23:0] pixel_out;
  logic valid_out, hsync_out, vsync_out, blank_out, cfg_pending_out;
  int checks = 0, errors = 0;

  video_compositor #(.NUM_BG(4), .NUM_OVL(2), .PIX_W(24)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bg_sel_in(bg_sel_in), .ovl_en_in(ovl_en_in),
    .ovl_blend_in(ovl_blend_in), .bg_pixel_in(bg_pixel_in), .ovl_mask_in(ovl_mask_in),
    .ovl_color_in(ovl_color_in), .valid_in(valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .blank_in(blank_in), .pixel_out(pixel_out), .valid_out(valid_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .blank_out(blank_out), .cfg_pending_out(cfg_pending_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  task automatic test_reset();
    vsync_in = 1'b1;
    bg_sel_in = 2'd2;
    step(3);
    checks++;
    if ({pixel_out, valid_out, hsync_out, vsync_out, blank_out} !== {24'h0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_outputs: got %h %b%b%b%b want 000000 0001", pixel_out, valid_out, hsync_out, vsync_out, blank_out);
    end
    valid_in = 1'b1;
    rst_in = 1'b0;
    step(3);
    checks++;
    if (pixel_out !== 24'h111111 || cfg_pending_out !== 1'b1) begin
      errors++;
      $display("FAIL held_vsync_no_edge: pixel %h pending %b want 111111 1", pixel_out, cfg_pending_out);
    end
    vsync_in = 1'b0;
    bg_sel_in = 2'd0;
    step();
    checks++;
    if (cfg_pending_out !== 1'b0) begin
      errors++;
      $display("FAIL pending_clear: got %b want 0", cfg_pending_out);
    end
    hsync_in = 1'b1;
    step(2);
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if ({pixel_out, valid_out, hsync_out, vsync_out, blank_out} !== {24'h0, 4'b0001}) begin
      errors++;
      $display("FAIL async_reset: got %h %b%b%b%b want 000000 0001", pixel_out, valid_out, hsync_out, vsync_out, blank_out);
    end
    hsync_in = 1'b0;
    valid_in = 1'b0;
    step();
    rst_in = 1'b0;
    step();
    valid_in = 1'b1;
    step();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL first_valid_early: got %b want 0", valid_out);
    end
    step();
    checks++;
    if (valid_out !== 1'b1) begin
      errors++;
      $display("FAIL first_valid_latency: got %b want 1", valid_out);
    end
  endtask

  task automatic test_bg_switch();
    bg_sel_in = 2'd2;
    step(3);
    checks++;
    if (pixel_out !== 24'h111111 || cfg_pending_out !== 1'b1) begin
      errors++;
      $display("FAIL bg_hold_midframe: pixel %h pending %b want 111111 1", pixel_out, cfg_pending_out);
    end
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    checks++;
    if (cfg_pending_out !== 1'b0) begin
      errors++;
      $display("FAIL bg_pending_after_edge: got %b want 0", cfg_pending_out);
    end
    step();
    checks++;
    if (pixel_out !== 24'h111111 || vsync_out !== 1'b1) begin
      errors++;
      $display("FAIL bg_edge_cycle_old: pixel %h vsync %b want 111111 1", pixel_out, vsync_out);
    end
    step();
    checks++;
    if (pixel_out !== 24'h333333 || vsync_out !== 1'b0) begin
      errors++;
      $display("FAIL bg_new_source: pixel %h vsync %b want 333333 0", pixel_out, vsync_out);
    end
  endtask

  task automatic test_overlay_priority();
    ovl_en_in = 2'b11;
    vsync_pulse();
    ovl_color_in = {24'hFF0000, 24'h00FF00};
    ovl_mask_in = 2'b11;
    step(2);
    checks++;
    if (pixel_out !== 24'h00FF00) begin
      errors++;
      $display("FAIL ovl_both: got %h want 00FF00", pixel_out);
    end
    ovl_mask_in = 2'b10;
    step(2);
    checks++;
    if (pixel_out !== 24'hFF0000) begin
      errors++;
      $display("FAIL ovl_second: got %h want FF0000", pixel_out);
    end
    ovl_mask_in = 2'b00;
    step(2);
    checks++;
    if (pixel_out !== 24'h333333) begin
      errors++;
      $display("FAIL ovl_none: got %h want 333333", pixel_out);
    end
    ovl_en_in = 2'b10;
    ovl_mask_in = 2'b11;
    step(2);
    checks++;
    if (pixel_out !== 24'h00FF00) begin
      errors++;
      $display("FAIL en_ignored_midframe: got %h want 00FF00", pixel_out);
    end
    vsync_pulse();
    step(2);
    checks++;
    if (pixel_out !== 24'hFF0000) begin
      errors++;
      $display("FAIL en_gate: got %h want FF0000", pixel_out);
    end
  endtask

  task automatic test_blanking();
    blank_in = 1'b1;
    step();
    blank_in = 1'b0;
    step();
    checks++;
    if (pixel_out !== 24'h000000 || blank_out !== 1'b1) begin
      errors++;
      $display("FAIL blank: pixel %h blank %b want 000000 1", pixel_out, blank_out);
    end
    step();
    checks++;
    if (pixel_out !== 24'hFF0000 || blank_out !== 1'b0) begin
      errors++;
      $display("FAIL unblank: pixel %h blank %b want FF0000 0", pixel_out, blank_out);
    end
  endtask

  task automatic test_blend();
    logic [23:0] want;
`ifdef VIDEO_COMPOSITOR_BLEND_EN
    want = 24'h7FBF20;
`else
    want = 24'h00FF00;
`endif
    bg_pixel_in[23:0] = 24'hFF8040;
    bg_sel_in = 2'd0;
    ovl_en_in = 2'b01;
    ovl_blend_in = 2'b01;
    vsync_pulse();
    ovl_mask_in = 2'b01;
    ovl_color_in = {24'hFF0000, 24'h00FF00};
    step(2);
    checks++;
    if (pixel_out !== want) begin
      errors++;
      $display("FAIL blend: got %h want %h", pixel_out, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] h [40];
    for (int k = 0; k < 40; k++) begin
      h[k] = 4'($urandom_range(0, 15));
      {valid_in, hsync_in, vsync_in, blank_in} = h[k];
      step();
      if (k >= 1) begin
        checks++;
        if ({valid_out, hsync_out, vsync_out, blank_out} !== h[k-1] || (h[k-1][0] && pixel_out !== 24'h0)) begin
          errors++;
          $display("FAIL align_%0d: got %b px %h want %b", k, {valid_out, hsync_out, vsync_out, blank_out}, pixel_out, h[k-1]);
        end
      end
    end
  endtask

  initial begin
    bg_pixel_in = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    test_reset();
    test_bg_switch();
    test_overlay_priority();
    test_blanking();
    test_blend();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
